// File: rtl/tqvp_bus_pkg.sv
// Shared encodings for the TinyQV peripheral bus initiator: transfer sizes,
// the idle strobe value, FSM state names and the size-to-byte-lane mask.
package tqvp_bus_pkg;

   localparam logic [1:0] SIZE_8   = 2'b00;
   localparam logic [1:0] SIZE_16  = 2'b01;
   localparam logic [1:0] SIZE_32  = 2'b10;
   localparam logic [1:0] BUS_IDLE = 2'b11;

   typedef enum logic [1:0] {
      IDLE  = 2'b00,
      WRITE = 2'b01,
      READ  = 2'b10,
      RESP  = 2'b11
   } state_t;

   // Keep only the byte lanes that a transfer of the given size carries.
   function automatic logic [31:0] size_mask(input logic [1:0] size);
      case (size)
         SIZE_8:  return 32'h0000_00FF;
         SIZE_16: return 32'h0000_FFFF;
         SIZE_32: return 32'hFFFF_FFFF;
         default: return 32'hFFFF_FFFF;
      endcase
   endfunction

endpackage

// File: rtl/tqvp_nkanderson_bus_initiator.sv
// Purpose: drives single 8/16/32-bit TinyQV peripheral reads/writes from a command stream, returns data/error.
// Latency: accept at cycle 0 -> write or immediate-ready read responds at cycle 2; reads time out after TIMEOUT_CYCLES.
// Backpressure: one transaction outstanding; cmd_ready only in IDLE, response held until rsp_ready.
module tqvp_nkanderson_bus_initiator
   import tqvp_bus_pkg::*;
#(
   parameter int TIMEOUT_CYCLES = 16
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        cmd_valid,
   output logic        cmd_ready,
   input  logic        cmd_write,
   input  logic [1:0]  cmd_size,
   input  logic [5:0]  cmd_addr,
   input  logic [31:0] cmd_wdata,
   output logic        rsp_valid,
   input  logic        rsp_ready,
   output logic [31:0] rsp_rdata,
   output logic        rsp_error,
   output logic [5:0]  p_address,
   output logic [31:0] p_data_in,
   output logic [1:0]  p_data_write_n,
   output logic [1:0]  p_data_read_n,
   input  logic [31:0] p_data_out,
   input  logic        p_data_ready,
   input  logic        p_irq,
   output logic        irq_pending,
   input  logic        irq_clear
);

   localparam int CW = $clog2(TIMEOUT_CYCLES + 1);
   // Index of the last READ cycle in which data_ready is still honoured.
   localparam logic [CW-1:0] CNT_LAST = CW'(TIMEOUT_CYCLES - 1);

   state_t        state_q, state_d;
   logic [CW-1:0] cnt_q, cnt_d;
   logic [5:0]    addr_q, addr_d;
   logic [31:0]   din_q, din_d;
   logic [1:0]    wn_q, wn_d;
   logic [1:0]    rn_q, rn_d;
   logic [31:0]   rdata_q, rdata_d;
   logic          err_q, err_d;
   logic          irq_prev_q;
   logic          irq_pending_q;
   logic          accept;

   assign accept    = cmd_valid && (state_q == IDLE);
   assign cmd_ready = (state_q == IDLE);
   assign rsp_valid = (state_q == RESP);

   assign p_address      = addr_q;
   assign p_data_in      = din_q;
   assign p_data_write_n = wn_q;
   assign p_data_read_n  = rn_q;
   assign rsp_rdata      = rdata_q;
   assign rsp_error      = err_q;
   assign irq_pending    = irq_pending_q;

   // State register.
   always_ff @(posedge clk) begin
      if (rst) state_q <= IDLE;
      else     state_q <= state_d;
   end

   // Next-state: illegal sizes skip the bus and go straight to the error response.
   always_comb begin
      state_d = state_q;
      case (state_q)
         IDLE: begin
            if (accept) begin
               if (cmd_size == BUS_IDLE) state_d = RESP;
               else if (cmd_write)       state_d = WRITE;
               else                      state_d = READ;
            end
         end
         WRITE:   state_d = RESP;
         READ:    if (p_data_ready || (cnt_q == CNT_LAST)) state_d = RESP;
         RESP:    if (rsp_ready) state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   // Output next-values: strobes carry the size for one write cycle or until a read completes/times out.
   always_comb begin
      cnt_d   = cnt_q;
      addr_d  = addr_q;
      din_d   = din_q;
      wn_d    = wn_q;
      rn_d    = rn_q;
      rdata_d = rdata_q;
      err_d   = err_q;
      case (state_q)
         IDLE: begin
            if (accept) begin
               cnt_d   = '0;
               rdata_d = '0;
               err_d   = (cmd_size == BUS_IDLE);
               if (cmd_size != BUS_IDLE) begin
                  addr_d = cmd_addr;
                  if (cmd_write) begin
                     wn_d  = cmd_size;
                     din_d = cmd_wdata & size_mask(cmd_size);
                  end else begin
                     rn_d = cmd_size;
                  end
               end
            end
         end
         WRITE: wn_d = BUS_IDLE;
         READ: begin
            cnt_d = cnt_q + CW'(1);
            // rn_q still holds the transfer size while the read is in flight.
            if (p_data_ready) begin
               rdata_d = p_data_out & size_mask(rn_q);
               rn_d    = BUS_IDLE;
            end else if (cnt_q == CNT_LAST) begin
               rdata_d = '0;
               err_d   = 1'b1;
               rn_d    = BUS_IDLE;
            end
         end
         default: ;
      endcase
   end

   // Registered bus and response outputs; reset forces the bus idle and drops any transaction.
   always_ff @(posedge clk) begin
      if (rst) begin
         cnt_q   <= '0;
         addr_q  <= '0;
         din_q   <= '0;
         wn_q    <= BUS_IDLE;
         rn_q    <= BUS_IDLE;
         rdata_q <= '0;
         err_q   <= 1'b0;
      end else begin
         cnt_q   <= cnt_d;
         addr_q  <= addr_d;
         din_q   <= din_d;
         wn_q    <= wn_d;
         rn_q    <= rn_d;
         rdata_q <= rdata_d;
         err_q   <= err_d;
      end
   end

   // Sticky interrupt on p_irq rising edge; a new edge beats a simultaneous clear.
   always_ff @(posedge clk) begin
      if (rst) begin
         irq_prev_q    <= 1'b0;
         irq_pending_q <= 1'b0;
      end else begin
         irq_prev_q <= p_irq;
         if (p_irq && !irq_prev_q) irq_pending_q <= 1'b1;
         else if (irq_clear)       irq_pending_q <= 1'b0;
      end
   end

endmodule

// File: tb/tb_tqvp_nkanderson_bus_initiator.sv
// Directed bench for the bus initiator: writes, reads with a programmable-delay
// responder, read timeout, illegal size with response backpressure, interrupt edge capture and reset mid-read.
module tb_tqvp_nkanderson_bus_initiator;

   logic        clk = 1'b0;
   logic        rst;
   logic        cmd_valid;
   logic        cmd_ready;
   logic        cmd_write;
   logic [1:0]  cmd_size;
   logic [5:0]  cmd_addr;
   logic [31:0] cmd_wdata;
   logic        rsp_valid;
   logic        rsp_ready;
   logic [31:0] rsp_rdata;
   logic        rsp_error;
   logic [5:0]  p_address;
   logic [31:0] p_data_in;
   logic [1:0]  p_data_write_n;
   logic [1:0]  p_data_read_n;
   logic [31:0] p_data_out;
   logic        p_data_ready;
   logic        p_irq;
   logic        irq_pending;
   logic        irq_clear;

   int total = 0;
   int bad   = 0;

   // Responder: answers combinationally once read_n has been low for rd_delay cycles.
   logic rd_en    = 1'b0;
   int   rd_delay = 0;
   int   rd_cnt   = 0;

   always #5 clk = ~clk;

   always @(posedge clk) begin
      if (p_data_read_n == 2'b11) rd_cnt <= 0;
      else                        rd_cnt <= rd_cnt + 1;
   end

   assign p_data_ready = rd_en && (p_data_read_n != 2'b11) && (rd_cnt == rd_delay);

   tqvp_nkanderson_bus_initiator #(.TIMEOUT_CYCLES(8)) dut (
      .clk            (clk),
      .rst            (rst),
      .cmd_valid      (cmd_valid),
      .cmd_ready      (cmd_ready),
      .cmd_write      (cmd_write),
      .cmd_size       (cmd_size),
      .cmd_addr       (cmd_addr),
      .cmd_wdata      (cmd_wdata),
      .rsp_valid      (rsp_valid),
      .rsp_ready      (rsp_ready),
      .rsp_rdata      (rsp_rdata),
      .rsp_error      (rsp_error),
      .p_address      (p_address),
      .p_data_in      (p_data_in),
      .p_data_write_n (p_data_write_n),
      .p_data_read_n  (p_data_read_n),
      .p_data_out     (p_data_out),
      .p_data_ready   (p_data_ready),
      .p_irq          (p_irq),
      .irq_pending    (irq_pending),
      .irq_clear      (irq_clear)
   );

   task automatic tick;
      @(posedge clk);
      #1;
   endtask

   task automatic test_reset;
      rst = 1'b1;
      tick;
      tick;
      total++; if (cmd_ready !== 1'b1) begin bad++; $display("FAIL reset_cmd_ready got %b want 1", cmd_ready); end
      total++; if (rsp_valid !== 1'b0) begin bad++; $display("FAIL reset_rsp_valid got %b want 0", rsp_valid); end
      total++; if (rsp_rdata !== 32'h0) begin bad++; $display("FAIL reset_rdata got %h want 0", rsp_rdata); end
      total++; if (rsp_error !== 1'b0) begin bad++; $display("FAIL reset_error got %b want 0", rsp_error); end
      total++; if (p_address !== 6'h0) begin bad++; $display("FAIL reset_addr got %h want 0", p_address); end
      total++; if (p_data_in !== 32'h0) begin bad++; $display("FAIL reset_data_in got %h want 0", p_data_in); end
      total++; if (p_data_write_n !== 2'b11) begin bad++; $display("FAIL reset_write_n got %b want 11", p_data_write_n); end
      total++; if (p_data_read_n !== 2'b11) begin bad++; $display("FAIL reset_read_n got %b want 11", p_data_read_n); end
      total++; if (irq_pending !== 1'b0) begin bad++; $display("FAIL reset_irq got %b want 0", irq_pending); end
      rst = 1'b0;
      tick;
   endtask

   task automatic test_write(input logic [1:0] sz, input logic [5:0] a,
                             input logic [31:0] wd, input logic [31:0] exp_din);
      cmd_valid = 1'b1; cmd_write = 1'b1; cmd_size = sz; cmd_addr = a; cmd_wdata = wd;
      rsp_ready = 1'b1;
      tick;
      cmd_valid = 1'b0;
      total++; if (p_data_write_n !== sz) begin bad++; $display("FAIL wr_strobe got %b want %b", p_data_write_n, sz); end
      total++; if (p_address !== a) begin bad++; $display("FAIL wr_addr got %h want %h", p_address, a); end
      total++; if (p_data_in !== exp_din) begin bad++; $display("FAIL wr_data got %h want %h", p_data_in, exp_din); end
      total++; if (p_data_read_n !== 2'b11) begin bad++; $display("FAIL wr_read_n got %b want 11", p_data_read_n); end
      total++; if (rsp_valid !== 1'b0) begin bad++; $display("FAIL wr_early_rsp got %b want 0", rsp_valid); end
      total++; if (cmd_ready !== 1'b0) begin bad++; $display("FAIL wr_cmd_ready got %b want 0", cmd_ready); end
      tick;
      total++; if (p_data_write_n !== 2'b11) begin bad++; $display("FAIL wr_strobe_end got %b want 11", p_data_write_n); end
      total++; if (rsp_valid !== 1'b1) begin bad++; $display("FAIL wr_rsp_valid got %b want 1", rsp_valid); end
      total++; if (rsp_error !== 1'b0) begin bad++; $display("FAIL wr_error got %b want 0", rsp_error); end
      total++; if (rsp_rdata !== 32'h0) begin bad++; $display("FAIL wr_rdata got %h want 0", rsp_rdata); end
      tick;
      total++; if (rsp_valid !== 1'b0) begin bad++; $display("FAIL wr_rsp_done got %b want 0", rsp_valid); end
      total++; if (cmd_ready !== 1'b1) begin bad++; $display("FAIL wr_idle got %b want 1", cmd_ready); end
   endtask

   task automatic test_read(input logic [1:0] sz, input logic [5:0] a, input logic [31:0] dout,
                            input int delay, input logic en, input int exp_cycles,
                            input logic [31:0] exp_rdata, input logic exp_err);
      int   n;
      logic bad_strobe;
      rd_en = en; rd_delay = delay; p_data_out = dout;
      cmd_valid = 1'b1; cmd_write = 1'b0; cmd_size = sz; cmd_addr = a; cmd_wdata = 32'hFFFF_FFFF;
      rsp_ready = 1'b1;
      tick;
      cmd_valid = 1'b0;
      n = 0;
      bad_strobe = 1'b0;
      while (p_data_read_n !== 2'b11 && n < 40) begin
         if (p_data_read_n !== sz || p_address !== a || p_data_write_n !== 2'b11 || rsp_valid !== 1'b0)
            bad_strobe = 1'b1;
         n++;
         tick;
      end
      total++; if (n != exp_cycles) begin bad++; $display("FAIL rd_cycles got %0d want %0d", n, exp_cycles); end
      total++; if (bad_strobe !== 1'b0) begin bad++; $display("FAIL rd_strobe_hold got %b want 0", bad_strobe); end
      total++; if (rsp_valid !== 1'b1) begin bad++; $display("FAIL rd_rsp_valid got %b want 1", rsp_valid); end
      total++; if (rsp_rdata !== exp_rdata) begin bad++; $display("FAIL rd_rdata got %h want %h", rsp_rdata, exp_rdata); end
      total++; if (rsp_error !== exp_err) begin bad++; $display("FAIL rd_error got %b want %b", rsp_error, exp_err); end
      tick;
      total++; if (rsp_valid !== 1'b0) begin bad++; $display("FAIL rd_rsp_done got %b want 0", rsp_valid); end
      rd_en = 1'b0;
   endtask

   task automatic test_illegal_size;
      cmd_valid = 1'b1; cmd_write = 1'b1; cmd_size = 2'b11; cmd_addr = 6'h15; cmd_wdata = 32'h5555_AAAA;
      rsp_ready = 1'b0;
      tick;
      cmd_valid = 1'b0;
      for (int i = 0; i < 4; i++) begin
         total++; if (rsp_valid !== 1'b1) begin bad++; $display("FAIL ill_rsp_valid[%0d] got %b want 1", i, rsp_valid); end
         total++; if (rsp_error !== 1'b1) begin bad++; $display("FAIL ill_error[%0d] got %b want 1", i, rsp_error); end
         total++; if (rsp_rdata !== 32'h0) begin bad++; $display("FAIL ill_rdata[%0d] got %h want 0", i, rsp_rdata); end
         total++; if (cmd_ready !== 1'b0) begin bad++; $display("FAIL ill_cmd_ready[%0d] got %b want 0", i, cmd_ready); end
         total++; if (p_data_write_n !== 2'b11 || p_data_read_n !== 2'b11) begin
            bad++; $display("FAIL ill_bus_idle[%0d] got %b/%b want 11/11", i, p_data_write_n, p_data_read_n);
         end
         if (i == 3) rsp_ready = 1'b1;
         tick;
      end
      total++; if (rsp_valid !== 1'b0) begin bad++; $display("FAIL ill_rsp_done got %b want 0", rsp_valid); end
      total++; if (cmd_ready !== 1'b1) begin bad++; $display("FAIL ill_idle got %b want 1", cmd_ready); end
   endtask

   task automatic test_back_to_back;
      // cmd_valid stays high: second write must wait for the cycle after the response handshake.
      cmd_valid = 1'b1; cmd_write = 1'b1; cmd_size = 2'b01; cmd_addr = 6'h07; cmd_wdata = 32'h1111_2222;
      rsp_ready = 1'b1;
      tick;
      total++; if (p_data_write_n !== 2'b01) begin bad++; $display("FAIL b2b_first got %b want 01", p_data_write_n); end
      tick;
      total++; if (rsp_valid !== 1'b1) begin bad++; $display("FAIL b2b_rsp got %b want 1", rsp_valid); end
      tick;
      total++; if (cmd_ready !== 1'b1 || p_data_write_n !== 2'b11) begin
         bad++; $display("FAIL b2b_gap got %b/%b want 1/11", cmd_ready, p_data_write_n);
      end
      cmd_wdata = 32'h3333_4444;
      tick;
      cmd_valid = 1'b0;
      total++; if (p_data_write_n !== 2'b01 || p_data_in !== 32'h0000_4444) begin
         bad++; $display("FAIL b2b_second got %b/%h want 01/00004444", p_data_write_n, p_data_in);
      end
      tick;
      tick;
      total++; if (cmd_ready !== 1'b1) begin bad++; $display("FAIL b2b_idle got %b want 1", cmd_ready); end
   endtask

   task automatic test_irq;
      p_irq = 1'b0; irq_clear = 1'b0;
      tick;
      p_irq = 1'b1;
      tick;
      total++; if (irq_pending !== 1'b1) begin bad++; $display("FAIL irq_set got %b want 1", irq_pending); end
      tick;
      total++; if (irq_pending !== 1'b1) begin bad++; $display("FAIL irq_sticky got %b want 1", irq_pending); end
      irq_clear = 1'b1;
      tick;
      irq_clear = 1'b0;
      total++; if (irq_pending !== 1'b0) begin bad++; $display("FAIL irq_clear got %b want 0", irq_pending); end
      tick;
      tick;
      total++; if (irq_pending !== 1'b0) begin bad++; $display("FAIL irq_level_no_reset got %b want 0", irq_pending); end
      p_irq = 1'b0;
      tick;
      p_irq = 1'b1; irq_clear = 1'b1;
      tick;
      irq_clear = 1'b0; p_irq = 1'b0;
      total++; if (irq_pending !== 1'b1) begin bad++; $display("FAIL irq_set_beats_clear got %b want 1", irq_pending); end
      irq_clear = 1'b1;
      tick;
      irq_clear = 1'b0;
   endtask

   task automatic test_reset_mid_read;
      rd_en = 1'b0;
      cmd_valid = 1'b1; cmd_write = 1'b0; cmd_size = 2'b00; cmd_addr = 6'h09;
      rsp_ready = 1'b1;
      tick;
      cmd_valid = 1'b0;
      tick;
      total++; if (p_data_read_n !== 2'b00) begin bad++; $display("FAIL rst_mid_active got %b want 00", p_data_read_n); end
      rst = 1'b1;
      tick;
      rst = 1'b0;
      total++; if (p_data_read_n !== 2'b11) begin bad++; $display("FAIL rst_mid_read_n got %b want 11", p_data_read_n); end
      total++; if (cmd_ready !== 1'b1) begin bad++; $display("FAIL rst_mid_idle got %b want 1", cmd_ready); end
      for (int i = 0; i < 10; i++) begin
         total++; if (rsp_valid !== 1'b0) begin bad++; $display("FAIL rst_mid_no_rsp[%0d] got %b want 0", i, rsp_valid); end
         tick;
      end
   endtask

   initial begin
      rst = 1'b1; cmd_valid = 1'b0; cmd_write = 1'b0; cmd_size = 2'b00; cmd_addr = 6'h0;
      cmd_wdata = 32'h0; rsp_ready = 1'b0; p_data_out = 32'h0; p_irq = 1'b0; irq_clear = 1'b0;
      test_reset;
      test_write(2'b10, 6'h02, 32'h1234_5678, 32'h1234_5678);
      test_write(2'b00, 6'h05, 32'hDEAD_BEEF, 32'h0000_00EF);
      test_write(2'b01, 6'h3F, 32'hCAFE_F00D, 32'h0000_F00D);
      // immediate combinational responder, 8-bit
      test_read(2'b00, 6'h04, 32'hA5A5_0003, 0, 1'b1, 1, 32'h0000_0003, 1'b0);
      // ready after 5 wait cycles, 16-bit
      test_read(2'b01, 6'h11, 32'h1234_ABCD, 5, 1'b1, 6, 32'h0000_ABCD, 1'b0);
      // ready in the last allowed cycle, 32-bit
      test_read(2'b10, 6'h20, 32'h8765_4321, 7, 1'b1, 8, 32'h8765_4321, 1'b0);
      // never ready: strobe for exactly 8 cycles, then error
      test_read(2'b01, 6'h08, 32'hFFFF_FFFF, 0, 1'b0, 8, 32'h0000_0000, 1'b1);
      test_illegal_size;
      test_back_to_back;
      test_irq;
      test_reset_mid_read;
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation exceeded time limit, total=%0d bad=%0d", total, bad);
      $fatal(1);
   end

endmodule
